// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative RV32M multiply/divide unit.
// The master side belongs to the execute stage and the slave side to the unit.
interface muldiv_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic [TAG_W-1:0] tag_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;
  logic             busy;

  modport master (
    output in_valid, op, a, b, tag_in, flush, out_ready,
    input  in_ready, out_valid, result, tag_out, busy
  );

  modport slave (
    input  in_valid, op, a, b, tag_in, flush, out_ready,
    output in_ready, out_valid, result, tag_out, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine, radix-2, one bit per cycle.
// Multiply is shift-add and divide is restoring; both work on operand
// magnitudes and the sign is applied when the last iteration retires.
// Divide-by-zero and signed overflow are resolved at accept, with no iterations.
// Optional feature macro MULDIV_FAST_MUL_EN: multiplies use one combinational
// XLEN x XLEN multiplier and finish at accept; divide stays iterative.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  hi, lo, mcand, res_q;
  logic             neg_q, negr_q;

  // Negate the magnitude product if needed and pick the low or high half.
  function automatic logic [XLEN-1:0] mul_final(input logic [1:0] f,
                                                input logic [2*XLEN-1:0] p,
                                                input logic neg);
    logic [2*XLEN-1:0] s;
    s = neg ? -p : p;
    return (f == 2'b00) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
  endfunction

  // ---- request decode (valid only while IDLE) ----
  logic            is_div, sa, sb, b_zero, ovf, special, accept;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  assign is_div = bus.op[2];
  // MULH: both signed; MULHSU: only a; DIV/REM: both signed; the rest unsigned.
  assign sa = bus.a[XLEN-1] & (is_div ? ~bus.op[0]
                                      : (bus.op[1:0] == 2'b01 || bus.op[1:0] == 2'b10));
  assign sb = bus.b[XLEN-1] & (is_div ? ~bus.op[0] : (bus.op[1:0] == 2'b01));
  assign mag_a = sa ? -bus.a : bus.a;
  assign mag_b = sb ? -bus.b : bus.b;

  assign b_zero  = is_div && (bus.b == '0);
  assign ovf     = is_div && !bus.op[0] && (bus.a == MIN_INT) && (bus.b == '1);
  assign special = b_zero || ovf;
  // op[1] selects the remainder flavour of a divide.
  assign special_res = b_zero ? (bus.op[1] ? bus.a : '1)
                              : (bus.op[1] ? '0 : MIN_INT);

  assign accept = (state == IDLE) && bus.in_valid && !bus.flush;

  logic            shortcut;
  logic [XLEN-1:0] shortcut_res;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod    = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
  assign shortcut     = special || !is_div;
  assign shortcut_res = special ? special_res : mul_final(bus.op[1:0], fast_prod, sa ^ sb);
`else
  assign shortcut     = special;
  assign shortcut_res = special_res;
`endif

  // ---- one iteration step on {hi, lo} ----
  logic [XLEN-1:0] hi_n, lo_n, calc_res;
  logic [XLEN:0]   sum, r_sh, diff;

  // Multiply: add multiplicand when lo[0] is set, shift right.
  // Divide: shift dividend bit into the partial remainder, trial subtract.
  always_comb begin
    hi_n = hi;
    lo_n = lo;
    sum  = '0;
    r_sh = '0;
    diff = '0;
    if (!op_q[2]) begin
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo[XLEN-1:1]};
    end else begin
      r_sh = {hi, lo[XLEN-1]};
      diff = r_sh - {1'b0, mcand};
      if (!diff[XLEN]) begin
        hi_n = diff[XLEN-1:0];
        lo_n = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_n = r_sh[XLEN-1:0];
        lo_n = {lo[XLEN-2:0], 1'b0};
      end
    end
  end

  // Divide: lo holds the quotient, hi the remainder after the final step.
  assign calc_res = op_q[2] ? (op_q[1] ? (negr_q ? -hi_n : hi_n)
                                       : (neg_q  ? -lo_n : lo_n))
                            : mul_final(op_q[1:0], {hi_n, lo_n}, neg_q);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; flush wins over everything, including accept.
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) state_nxt = shortcut ? DONE : CALC;
        CALC: if (cnt == '0)    state_nxt = DONE;
        DONE: if (bus.out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operand capture at accept, iteration in CALC, result load on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      op_q   <= '0;
      tag_q  <= '0;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      res_q  <= '0;
      neg_q  <= 1'b0;
      negr_q <= 1'b0;
    end else if (accept) begin
      cnt    <= CW'(XLEN-1);
      op_q   <= bus.op;
      tag_q  <= bus.tag_in;
      hi     <= '0;
      lo     <= mag_a;
      mcand  <= mag_b;
      neg_q  <= sa ^ sb;
      negr_q <= sa;
      if (shortcut) res_q <= shortcut_res;
    end else if (state == CALC && !bus.flush) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt - 1'b1;
      if (cnt == '0) res_q <= calc_res;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == CALC) || (state == DONE && !bus.out_ready);
  assign bus.result    = res_q;
  assign bus.tag_out   = tag_q;
endmodule
